// File: rtl/matmul_par_lanes.sv
// Multi-lane integer matrix multiplier R = A x B. Rows of A are dealt round-robin
// across LANES concurrent MAC engines, each doing one multiply-accumulate per cycle.
module matmul_par_lanes #(
   parameter int A_ROWS = 4,
   parameter int A_COLS = 4,
   parameter int B_COLS = 4,
   parameter int DW     = 8,
   parameter int ACC_W  = 18,
   parameter int LANES  = 2,
   parameter int SIGNED = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [A_ROWS*A_COLS*DW-1:0]    a,
   input  logic [A_COLS*B_COLS*DW-1:0]    b,
   output logic                           busy,
   output logic                           done,
   output logic [A_ROWS*B_COLS*ACC_W-1:0] res
);

   localparam int ROWS_PER_LANE = (A_ROWS + LANES - 1) / LANES;
   localparam int M   = ROWS_PER_LANE * B_COLS * A_COLS;
   localparam int RW  = $clog2(A_ROWS + 2*LANES);
   localparam int RIW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
   localparam int JW  = (B_COLS > 1) ? $clog2(B_COLS) : 1;
   localparam int KW  = (A_COLS > 1) ? $clog2(A_COLS) : 1;
   localparam int CW  = $clog2(M + 1);
   localparam int PW  = (ACC_W > 2*DW) ? ACC_W : 2*DW;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                           state_q, state_d;
   logic [A_ROWS*A_COLS*DW-1:0]      aCap_q, aCap_d;
   logic [A_COLS*B_COLS*DW-1:0]      bCap_q, bCap_d;
   logic [ACC_W-1:0]                 acc_q [A_ROWS][B_COLS];
   logic [ACC_W-1:0]                 acc_d [A_ROWS][B_COLS];
   logic [A_ROWS*B_COLS*ACC_W-1:0]   res_q, res_d;
   logic [RW-1:0]                    row_q [LANES];
   logic [RW-1:0]                    row_d [LANES];
   logic [JW-1:0]                    j_q   [LANES];
   logic [JW-1:0]                    j_d   [LANES];
   logic [KW-1:0]                    k_q   [LANES];
   logic [KW-1:0]                    k_d   [LANES];
   logic [CW-1:0]                    cnt_q, cnt_d;

   logic [DW-1:0] aElem [A_ROWS][A_COLS];
   logic [DW-1:0] bElem [A_COLS][B_COLS];

   // Unpack the captured operands; element (0,0) sits in the MSBs.
   for (genvar r = 0; r < A_ROWS; r++) begin : g_aRow
      for (genvar c = 0; c < A_COLS; c++) begin : g_aCol
         assign aElem[r][c] = aCap_q[DW*(A_ROWS*A_COLS-1-(r*A_COLS+c)) +: DW];
      end
   end

   for (genvar r = 0; r < A_COLS; r++) begin : g_bRow
      for (genvar c = 0; c < B_COLS; c++) begin : g_bCol
         assign bElem[r][c] = bCap_q[DW*(A_COLS*B_COLS-1-(r*B_COLS+c)) +: DW];
      end
   end

   // Operands are extended to PW bits first, so the low bits of the product are
   // exact for both signednesses before wrapping to ACC_W.
   function automatic logic [ACC_W-1:0] macTerm(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [PW-1:0] xe;
      logic [PW-1:0] ye;
      logic [PW-1:0] p;
      if (SIGNED != 0) begin
         xe = {{(PW-DW){x[DW-1]}}, x};
         ye = {{(PW-DW){y[DW-1]}}, y};
      end else begin
         xe = {{(PW-DW){1'b0}}, x};
         ye = {{(PW-DW){1'b0}}, y};
      end
      p = xe * ye;
      return p[ACC_W-1:0];
   endfunction

   always_comb begin
      state_d = state_q;
      aCap_d  = aCap_q;
      bCap_d  = bCap_q;
      acc_d   = acc_q;
      res_d   = res_q;
      row_d   = row_q;
      j_d     = j_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COMPUTE;
               aCap_d  = a;
               bCap_d  = b;
               cnt_d   = '0;
               for (int r = 0; r < A_ROWS; r++) begin
                  for (int c = 0; c < B_COLS; c++) begin
                     acc_d[r][c] = '0;
                  end
               end
               for (int l = 0; l < LANES; l++) begin
                  row_d[l] = RW'(l);
                  j_d[l]   = '0;
                  k_d[l]   = '0;
               end
            end
         end

         S_COMPUTE: begin
            busy = 1'b1;
            // Lanes own disjoint rows, so their accumulator writes never collide.
            for (int l = 0; l < LANES; l++) begin
               if (row_q[l] < RW'(A_ROWS)) begin
                  acc_d[RIW'(row_q[l])][j_q[l]] = acc_q[RIW'(row_q[l])][j_q[l]]
                     + macTerm(aElem[RIW'(row_q[l])][k_q[l]], bElem[k_q[l]][j_q[l]]);
                  if (k_q[l] == KW'(A_COLS-1)) begin
                     k_d[l] = '0;
                     if (j_q[l] == JW'(B_COLS-1)) begin
                        j_d[l]   = '0;
                        row_d[l] = row_q[l] + RW'(LANES);
                     end else begin
                        j_d[l] = j_q[l] + JW'(1);
                     end
                  end else begin
                     k_d[l] = k_q[l] + KW'(1);
                  end
               end
            end

            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(M-1)) begin
               state_d = S_DONE;
               for (int r = 0; r < A_ROWS; r++) begin
                  for (int c = 0; c < B_COLS; c++) begin
                     res_d[ACC_W*(A_ROWS*B_COLS-1-(r*B_COLS+c)) +: ACC_W] = acc_d[r][c];
                  end
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         aCap_q  <= '0;
         bCap_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         for (int r = 0; r < A_ROWS; r++) begin
            for (int c = 0; c < B_COLS; c++) begin
               acc_q[r][c] <= '0;
            end
         end
         for (int l = 0; l < LANES; l++) begin
            row_q[l] <= '0;
            j_q[l]   <= '0;
            k_q[l]   <= '0;
         end
      end else begin
         state_q <= state_d;
         aCap_q  <= aCap_d;
         bCap_q  <= bCap_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         for (int r = 0; r < A_ROWS; r++) begin
            for (int c = 0; c < B_COLS; c++) begin
               acc_q[r][c] <= acc_d[r][c];
            end
         end
         for (int l = 0; l < LANES; l++) begin
            row_q[l] <= row_d[l];
            j_q[l]   <= j_d[l];
            k_q[l]   <= k_d[l];
         end
      end
   end

   assign res = res_q;

endmodule

// File: tb/tb_matmul_par_lanes.sv
// Directed bench for matmul_par_lanes: a 2x2 signed instance driven from a vector
// table, plus four 4x4 instances (LANES 2/1/4 signed, LANES 2 unsigned 16-bit).
module tb_matmul_par_lanes;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 2x2 signed instance
   logic        rst2, start2, busy2, done2;
   logic [31:0] a2, b2;
   logic [71:0] res2;

   // 4x4 instances share their inputs
   logic         rst4, start4;
   logic [127:0] a4, b4;
   logic         busyL2, doneL2, busyL1, doneL1, busyL4, doneL4, busyU, doneU;
   logic [287:0] resL2, resL1, resL4;
   logic [255:0] resU;

   matmul_par_lanes #(.A_ROWS(2), .A_COLS(2), .B_COLS(2), .DW(8), .ACC_W(18), .LANES(2), .SIGNED(1)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .busy(busy2), .done(done2), .res(res2));

   matmul_par_lanes #(.LANES(2)) dutL2 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .busy(busyL2), .done(doneL2), .res(resL2));

   matmul_par_lanes #(.LANES(1)) dutL1 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .busy(busyL1), .done(doneL1), .res(resL1));

   matmul_par_lanes #(.LANES(4)) dutL4 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .busy(busyL4), .done(doneL4), .res(resL4));

   matmul_par_lanes #(.ACC_W(16), .LANES(2), .SIGNED(0)) dutU (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .busy(busyU), .done(doneU), .res(resU));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [71:0] r;
   } vec2_t;

   vec2_t vecs [5];

   function automatic logic [31:0] pack22(input int e00, input int e01, input int e10, input int e11);
      return {8'(e00), 8'(e01), 8'(e10), 8'(e11)};
   endfunction

   function automatic logic [71:0] res22(input int e00, input int e01, input int e10, input int e11);
      return {18'(e00), 18'(e01), 18'(e10), 18'(e11)};
   endfunction

   // 4x4 builders: value d on the diagonal, o everywhere else
   function automatic logic [127:0] mk8(input int d, input int o);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[8*(15-i) +: 8] = ((i/4) == (i%4)) ? 8'(d) : 8'(o);
      return v;
   endfunction

   function automatic logic [287:0] mk18(input int d, input int o);
      logic [287:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[18*(15-i) +: 18] = ((i/4) == (i%4)) ? 18'(d) : 18'(o);
      return v;
   endfunction

   function automatic logic [255:0] mk16(input int d, input int o);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[16*(15-i) +: 16] = ((i/4) == (i%4)) ? 16'(d) : 16'(o);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [287:0] act, input logic [287:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one 2x2 job; lat is the cycle (counting T+1 as 1) in which done is seen.
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, output int lat, output int busyCnt);
      @(negedge clk);
      a2 = av; b2 = bv; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = 0; busyCnt = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (busy2) busyCnt++;
         if (done2) begin
            lat = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic applyStimulusWide(input logic [127:0] av, input logic [127:0] bv,
                                    output int l2, output int l1, output int l4, output int lu);
      @(negedge clk);
      a4 = av; b4 = bv; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      l2 = 0; l1 = 0; l4 = 0; lu = 0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         if (doneL2 && l2 == 0) l2 = cyc;
         if (doneL1 && l1 == 0) l1 = cyc;
         if (doneL4 && l4 == 0) l4 = cyc;
         if (doneU  && lu == 0) lu = cyc;
         if (l2 != 0 && l1 != 0 && l4 != 0 && lu != 0) break;
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, bc, dc, l2, l1, l4, lu;

      vecs[0].a = pack22(1, 2, 3, 4);        vecs[0].b = pack22(1, 0, 0, 1);
      vecs[0].r = res22(1, 2, 3, 4);
      vecs[1].a = pack22(-1, 2, 3, -4);      vecs[1].b = pack22(5, 6, 7, 8);
      vecs[1].r = res22(9, 10, -13, -14);
      vecs[2].a = pack22(127, -128, 0, 1);   vecs[2].b = pack22(127, 0, -128, 1);
      vecs[2].r = res22(32513, -128, -128, 1);
      vecs[3].a = pack22(-128, -128, -128, -128); vecs[3].b = pack22(-128, -128, -128, -128);
      vecs[3].r = res22(32768, 32768, 32768, 32768);
      vecs[4].a = pack22(2, 3, 4, 5);        vecs[4].b = pack22(6, 7, 8, 9);
      vecs[4].r = res22(36, 41, 64, 73);

      rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0;
      rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      rst2 = 1'b0; rst4 = 1'b0;
      @(negedge clk);

      checkOutput("reset busy2", busy2, 0);
      checkOutput("reset done2", done2, 0);
      checkOutput("reset res2", res2, 0);
      checkOutput("reset busyL2", busyL2, 0);
      checkOutput("reset doneL1", doneL1, 0);
      checkOutput("reset resL4", resL4, 0);
      checkOutput("reset resU", resU, 0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat, bc);
         checkOutput($sformatf("vec%0d latency", i), lat, 5);
         checkOutput($sformatf("vec%0d busy cycles", i), bc, 4);
         checkOutput($sformatf("vec%0d res", i), res2, vecs[i].r);
      end

      // Result must hold after the job with no further done pulses.
      applyStimulus(vecs[1].a, vecs[1].b, lat, bc);
      dc = 0;
      repeat (6) begin
         @(negedge clk);
         if (done2) dc++;
      end
      checkOutput("hold res", res2, vecs[1].r);
      checkOutput("hold no done", dc, 0);

      // Operand change at T+2 and start at T+3 must not disturb the job.
      @(negedge clk);
      a2 = vecs[4].a; b2 = vecs[4].b; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
      a2 = vecs[1].a; b2 = vecs[1].b;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = 0;
      for (int cyc = 4; cyc <= 40; cyc++) begin
         if (done2) begin
            lat = cyc;
            break;
         end
         @(negedge clk);
      end
      checkOutput("ignore latency", lat, 5);
      checkOutput("ignore res", res2, vecs[4].r);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      bc = 0; dc = 0;
      repeat (8) begin
         if (busy2) bc++;
         if (done2) dc++;
         @(negedge clk);
      end
      checkOutput("no queued job busy", bc, 0);
      checkOutput("no queued job done", dc, 0);

      // Reset together with start mid-job discards everything.
      a2 = vecs[1].a; b2 = vecs[1].b; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
      rst2 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0; start2 = 1'b0;
      checkOutput("rst busy", busy2, 0);
      checkOutput("rst done", done2, 0);
      checkOutput("rst res", res2, 0);
      bc = 0; dc = 0;
      repeat (10) begin
         if (busy2) bc++;
         if (done2) dc++;
         @(negedge clk);
      end
      checkOutput("rst no busy", bc, 0);
      checkOutput("rst no done", dc, 0);
      applyStimulus(vecs[2].a, vecs[2].b, lat, bc);
      checkOutput("after rst latency", lat, 5);
      checkOutput("after rst res", res2, vecs[2].r);

      // 4x4: identity x identity
      applyStimulusWide(mk8(1, 0), mk8(1, 0), l2, l1, l4, lu);
      checkOutput("ident lat L2", l2, 33);
      checkOutput("ident lat L1", l1, 65);
      checkOutput("ident lat L4", l4, 17);
      checkOutput("ident lat U", lu, 33);
      checkOutput("ident res L2", resL2, mk18(1, 0));
      checkOutput("ident res L1", resL1, mk18(1, 0));
      checkOutput("ident res L4", resL4, mk18(1, 0));
      checkOutput("ident res U", resU, mk16(1, 0));

      // 4x4: all 0xFF; -1*-1 summed when signed, 255*255*4 wrapped to 16 bits when not
      applyStimulusWide(mk8(-1, -1), mk8(-1, -1), l2, l1, l4, lu);
      checkOutput("ff lat L4", l4, 17);
      checkOutput("ff res L2", resL2, mk18(4, 4));
      checkOutput("ff res L1", resL1, mk18(4, 4));
      checkOutput("ff res L4", resL4, mk18(4, 4));
      checkOutput("ff res U", resU, mk16(63492, 63492));

      // 4x4: mixed-sign operand (-2 off-diagonal reads as 254 unsigned)
      applyStimulusWide(mk8(3, -2), mk8(1, 0), l2, l1, l4, lu);
      checkOutput("mix ident res L2", resL2, mk18(3, -2));
      checkOutput("mix ident res U", resU, mk16(3, 254));
      applyStimulusWide(mk8(3, -2), mk8(3, -2), l2, l1, l4, lu);
      checkOutput("mix sq lat L1", l1, 65);
      checkOutput("mix sq res L2", resL2, mk18(21, -4));
      checkOutput("mix sq res L1", resL1, mk18(21, -4));
      checkOutput("mix sq res L4", resL4, mk18(21, -4));
      checkOutput("mix sq res U", resU, mk16(62485, 65020));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_par_lanes.md
Name: matmul_par_lanes

Overview:
Parametrised, multi-lane signed/unsigned integer matrix multiplier computing R = A x B for A (A_ROWS x A_COLS) and B (A_COLS x B_COLS).
- Rows of A are split round-robin across LANES independent MAC engines that run concurrently. Each engine performs one multiply-accumulate per cycle.
- Operands are captured once under a start/done handshake. The result is held on a flat output bus until the next job.
- Next-generation compute block of the matrix datapath: adds lane count, element/accumulator width, signedness, a proper handshake and registered result output.

Parameters:
- A_ROWS, 4, rows of A and of R.
- A_COLS, 4, columns of A = rows of B (compatibility is guaranteed by construction).
- B_COLS, 4, columns of B and of R.
- DW, 8, element width of A and B.
- ACC_W, 18, result element width. Must be >= 1.
- LANES, 2, number of parallel MAC engines, 1..A_ROWS.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- a  in  A_ROWS*A_COLS*DW  packed A; element (r,c) at bits [DW*(A_ROWS*A_COLS-1-(r*A_COLS+c)) +: DW], so (0,0) is in the MSBs.
- b  in  A_COLS*B_COLS*DW  packed B, same row-major MSB-first packing.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when res becomes valid.
- res  out  A_ROWS*B_COLS*ACC_W  packed R, element (r,c) at [ACC_W*(A_ROWS*B_COLS-1-(r*B_COLS+c)) +: ACC_W].

Behaviour:
- Reset values: busy=0, done=0, res=0, state=IDLE, all lane counters and accumulators 0.
- States are IDLE, COMPUTE and DONE.
- IDLE:
  - On an edge where start=1, register a and b internally and clear all accumulators.
  - Lane counters are initialised as follows: lane L starts at row L, j=0, k=0.
  - Transition to COMPUTE.
- COMPUTE (busy=1):
  - Each cycle, every active lane does acc[row][j] += ext(A[row][k]) * ext(B[k][j]).
  - ext() sign-extends when SIGNED=1 and zero-extends when SIGNED=0. The full product is formed, then truncated/extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
  - Iteration order per lane: k innermost, then j, then row (row += LANES).
  - There are no bubble cycles between k/j/row rollovers.
  - A lane whose next row is >= A_ROWS goes idle and holds.
  - Job length M = ceil(A_ROWS/LANES) * B_COLS * A_COLS cycles.
- Lane exclusivity: no two lanes ever write the same accumulator element.
- COMPUTE -> DONE after the M-th MAC cycle, at which point res is loaded from the accumulators.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T. busy is high in cycles T+1..T+M. done and the new res are visible in cycle T+M+1.
- res holds its value from the DONE cycle until the next DONE or rst. It does not change during COMPUTE.
- Inputs a/b may change freely after the start edge, since only the captured copy is used.
- start while busy or in DONE is ignored, with no queueing.
- rst mid-operation: next cycle is IDLE, busy=0, done=0, res=0; the in-flight job is discarded.
- rst and start in the same cycle: rst wins.
- LANES=A_ROWS: each lane handles exactly one row. LANES=1: fully serial, M = A_ROWS*B_COLS*A_COLS.

Test Plan:
- A_ROWS=A_COLS=B_COLS=2, LANES=2, SIGNED=1, A=[[1,2],[3,4]], B=identity, start pulse at T -> busy in T+1..T+4, done at T+5, res=[[1,2],[3,4]].
- Same config, A=[[-1,2],[3,-4]], B=[[5,6],[7,8]] -> res=[[9,10],[-13,-14]] as ACC_W two's-complement; res stays stable afterwards until the next job.
- Defaults (4x4x4, LANES=2), A=B=identity -> done exactly 33 cycles after start (M=32), res=identity. Repeat with LANES=1 -> 65 cycles; with LANES=4 -> 17 cycles.
- SIGNED=0, ACC_W=16, 4x4 all-255 A and B -> every res element = 63492 (0xF804, wrap check).
- Assert start again at T+3 during a job, and change a/b at T+2 -> ignored; done still at the original time with the original result.
- rst=1 at T+2 together with start -> IDLE next cycle, res=0, no done pulse. A fresh start afterwards produces the correct result.
